// File: rtl/uart_rx_mem_core.sv
// uart_rx_mem_core: UART receiver (8N1, 8x oversampled) with a small byte memory.
//
// Receiver states
//   state | meaning
//   IDLE  | line idle, waiting for a low sample on a bclk_x8 tick
//   START | qualifying the start bit; line re-checked on the 4th tick (bit centre)
//   DATA  | sampling 8 data bits, one every 8 ticks, LSB first
//   STOP  | sampling the stop bit 8 ticks after the last data bit, then report
module uart_rx_mem_core #(
    parameter int CLK_HZ   = 768000,
    parameter int BAUD_SEL = 0,
    parameter int ROW      = 2,
    parameter int COLUMN   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_data,
    input  logic        mem_write,
    input  logic [31:0] write_address,
    input  logic [7:0]  write_value,
    input  logic        mem_read,
    input  logic [31:0] read_address,
    output logic [7:0]  data,
    output logic        bclk,
    output logic        bclk_x8,
    output logic        rx_status,
    output logic [9:0]  rx_output,
    output logic        rx_valid,
    output logic        frame_error
);

    localparam int BAUD = (BAUD_SEL == 1) ? 19200 :
                          (BAUD_SEL == 2) ? 57600 :
                          (BAUD_SEL == 3) ? 115200 : 9600;
    localparam int DIV8      = CLK_HZ / (BAUD * 8);
    localparam int DIV8_SAFE = (DIV8 < 1) ? 1 : DIV8;
    localparam int CW        = $clog2(DIV8_SAFE + 1);
    localparam logic [CW-1:0] DIV_RELOAD = CW'(DIV8_SAFE - 1);

    localparam int DEPTH = ROW * COLUMN;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    logic [CW-1:0] r_div_cnt;
    logic [2:0]    r_x8_cnt;
    logic          r_bclk_x8;
    logic          r_bclk;

    logic          r_sync1;
    logic          r_sync2;

    rx_state_t     r_state;
    logic [2:0]    r_tick;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_status;
    logic [9:0]    r_rx_output;
    logic          r_rx_valid;
    logic          r_frame_error;

    logic [7:0]    r_mem [DEPTH];
    logic [7:0]    r_data;

    logic          w_div_zero;
    logic          w_wr_ok;
    logic          w_rd_ok;

    assign w_div_zero = (r_div_cnt == '0);
    assign w_wr_ok    = mem_write && (write_address < DEPTH_W);
    assign w_rd_ok    = read_address < DEPTH_W;

    // Baud generator: down-counter makes the 8x tick, every 8th tick makes bclk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= DIV_RELOAD;
            r_x8_cnt  <= 3'd0;
            r_bclk_x8 <= 1'b0;
            r_bclk    <= 1'b0;
        end else if (w_div_zero) begin
            r_div_cnt <= DIV_RELOAD;
            r_x8_cnt  <= r_x8_cnt + 3'd1;
            r_bclk_x8 <= 1'b1;
            r_bclk    <= (r_x8_cnt == 3'd7);
        end else begin
            r_div_cnt <= r_div_cnt - 1'b1;
            r_bclk_x8 <= 1'b0;
            r_bclk    <= 1'b0;
        end
    end

    // Two-flop synchronizer for the serial line; resets to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_data;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver FSM; advances only on cycles where bclk_x8 is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_tick        <= 3'd0;
            r_bit         <= 3'd0;
            r_shift       <= 8'h00;
            r_status      <= 1'b0;
            r_rx_output   <= 10'h000;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (r_bclk_x8) begin
                case (r_state)
                    IDLE: begin
                        if (!r_sync2) begin
                            r_state <= START;
                            r_tick  <= 3'd0;
                        end
                    end
                    START: begin
                        if (r_tick == 3'd3) begin
                            r_tick <= 3'd0;
                            r_bit  <= 3'd0;
                            if (!r_sync2) begin
                                r_state  <= DATA;
                                r_status <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_tick <= r_tick + 3'd1;
                        end
                    end
                    DATA: begin
                        if (r_tick == 3'd7) begin
                            r_tick  <= 3'd0;
                            r_shift <= {r_sync2, r_shift[7:1]};
                            if (r_bit == 3'd7) begin
                                r_state <= STOP;
                            end else begin
                                r_bit <= r_bit + 3'd1;
                            end
                        end else begin
                            r_tick <= r_tick + 3'd1;
                        end
                    end
                    STOP: begin
                        if (r_tick == 3'd7) begin
                            r_tick        <= 3'd0;
                            r_rx_output   <= {r_sync2, r_shift, 1'b0};
                            r_rx_valid    <= 1'b1;
                            r_frame_error <= ~r_sync2;
                            r_status      <= 1'b0;
                            r_state       <= IDLE;
                        end else begin
                            r_tick <= r_tick + 3'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Byte memory with registered read; old contents win on a same-address read/write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_data <= 8'h00;
        end else begin
            if (w_wr_ok) begin
                r_mem[write_address[AW-1:0]] <= write_value;
            end
            if (mem_read) begin
                r_data <= w_rd_ok ? r_mem[read_address[AW-1:0]] : 8'h00;
            end
        end
    end

    assign data        = r_data;
    assign bclk        = r_bclk;
    assign bclk_x8     = r_bclk_x8;
    assign rx_status   = r_status;
    assign rx_output   = r_rx_output;
    assign rx_valid    = r_rx_valid;
    assign frame_error = r_frame_error;

endmodule

// File: tb/tb_uart_rx_mem_core.sv
// Bench for uart_rx_mem_core at default parameters (80 clocks per UART bit).
module tb_uart_rx_mem_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_data;
    logic        mem_write;
    logic [31:0] write_address;
    logic [7:0]  write_value;
    logic        mem_read;
    logic [31:0] read_address;
    logic [7:0]  data;
    logic        bclk;
    logic        bclk_x8;
    logic        rx_status;
    logic [9:0]  rx_output;
    logic        rx_valid;
    logic        frame_error;

    localparam int BIT_CLKS = 80;

    typedef struct packed {
        logic [9:0] out;
        logic       fe;
    } rx_exp_t;

    rx_exp_t    rx_q[$];
    logic [7:0] rd_q[$];
    rx_exp_t    mon_e;
    logic [7:0] mon_d;
    logic       rd_prev = 1'b0;

    int errors = 0;
    int checks = 0;

    uart_rx_mem_core dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .mem_write     (mem_write),
        .write_address (write_address),
        .write_value   (write_value),
        .mem_read      (mem_read),
        .read_address  (read_address),
        .data          (data),
        .bclk          (bclk),
        .bclk_x8       (bclk_x8),
        .rx_status     (rx_status),
        .rx_output     (rx_output),
        .rx_valid      (rx_valid),
        .frame_error   (frame_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A read issued at a rising edge is compared at the following falling edge.
    always @(posedge clk) rd_prev <= mem_read;

    // Monitor: pops the scoreboard whenever the DUT presents a frame or read data.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got rx_output=0x%0h expected no frame", rx_output);
            end else begin
                mon_e = rx_q.pop_front();
                chk("rx_output", 32'(rx_output), 32'(mon_e.out));
                chk("frame_error", 32'(frame_error), 32'(mon_e.fe));
            end
        end
        if (rd_prev) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got data=0x%0h expected no read", data);
            end else begin
                mon_d = rd_q.pop_front();
                chk("read_data", 32'(data), 32'(mon_d));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic [9:0] exp_out);
        rx_exp_t e;
        e.out = exp_out;
        e.fe  = ~stop_b;
        rx_q.push_back(e);
        rx_data = 1'b0;
        idle(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_data = b[i];
            idle(BIT_CLKS / 2);
            if (i == 4) chk("rx_status_mid", 32'(rx_status), 32'd1);
            idle(BIT_CLKS / 2);
        end
        rx_data = stop_b;
        idle(BIT_CLKS);
        rx_data = 1'b1;
    endtask

    task automatic mem_wr(input logic [31:0] a, input logic [7:0] v);
        @(negedge clk);
        mem_write     = 1'b1;
        write_address = a;
        write_value   = v;
        @(negedge clk);
        mem_write     = 1'b0;
    endtask

    task automatic mem_rd(input logic [31:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_q.push_back(exp);
        mem_read     = 1'b1;
        read_address = a;
        @(negedge clk);
        mem_read     = 1'b0;
    endtask

    task automatic mem_rw(input logic [31:0] a, input logic [7:0] v, input logic [7:0] exp);
        @(negedge clk);
        rd_q.push_back(exp);
        mem_read      = 1'b1;
        read_address  = a;
        mem_write     = 1'b1;
        write_address = a;
        write_value   = v;
        @(negedge clk);
        mem_read      = 1'b0;
        mem_write     = 1'b0;
    endtask

    initial begin
        int  first_x8;
        int  second_x8;
        int  first_b;
        logic x8_wide;
        logic saw_status;

        rst_n         = 1'b0;
        rx_data       = 1'b1;
        mem_write     = 1'b0;
        write_address = 32'd0;
        write_value   = 8'h00;
        mem_read      = 1'b0;
        read_address  = 32'd0;

        idle(3);
        chk("reset_rx_output", 32'(rx_output), 32'h000);
        chk("reset_data", 32'(data), 32'h00);
        chk("reset_rx_status", 32'(rx_status), 32'd0);
        chk("reset_bclk_x8", 32'(bclk_x8), 32'd0);

        // Baud tick timing measured from reset release.
        rst_n     = 1'b1;
        first_x8  = 0;
        second_x8 = 0;
        first_b   = 0;
        x8_wide   = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (first_x8 != 0 && i == first_x8 + 1) x8_wide = bclk_x8;
            if (bclk_x8) begin
                if (first_x8 == 0) first_x8 = i;
                else if (second_x8 == 0) second_x8 = i;
            end
            if (bclk && first_b == 0) first_b = i;
        end
        chk("first_bclk_x8", 32'(first_x8), 32'd10);
        chk("second_bclk_x8", 32'(second_x8), 32'd20);
        chk("bclk_x8_width", 32'(x8_wide), 32'd0);
        chk("first_bclk", 32'(first_b), 32'd80);

        // Good frame, then a frame with a low stop bit, sent back to back.
        send_frame(8'hA5, 1'b1, 10'h34A);
        send_frame(8'h3C, 1'b0, 10'h078);
        idle(BIT_CLKS);
        chk("rx_status_after", 32'(rx_status), 32'd0);

        // Short low glitch on the idle line must not start a frame.
        rx_data = 1'b0;
        idle(20);
        rx_data = 1'b1;
        saw_status = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rx_status) saw_status = 1'b1;
        end
        chk("glitch_rx_status", 32'(saw_status), 32'd0);
        chk("glitch_holds_output", 32'(rx_output), 32'h078);

        // Memory: in-range writes, one out-of-range write, then reads.
        mem_wr(32'd0, 8'h11);
        mem_wr(32'd1, 8'h22);
        mem_wr(32'd2, 8'h33);
        mem_wr(32'd3, 8'h44);
        mem_wr(32'd4, 8'hFF);
        mem_rd(32'd0, 8'h11);
        mem_rd(32'd1, 8'h22);
        mem_rd(32'd2, 8'h33);
        mem_rd(32'd3, 8'h44);
        mem_rd(32'd4, 8'h00);
        mem_rw(32'd1, 8'h99, 8'h22);
        mem_rd(32'd1, 8'h99);
        mem_rd(32'hFFFF_FFFF, 8'h00);
        mem_rd(32'd3, 8'h44);
        idle(5);
        chk("data_hold", 32'(data), 32'h44);

        // Reset in the middle of a frame.
        rx_data = 1'b0;
        idle(BIT_CLKS * 3);
        chk("pre_reset_status", 32'(rx_status), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_rx_status", 32'(rx_status), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_frame_error", 32'(frame_error), 32'd0);
        chk("rst_rx_output", 32'(rx_output), 32'h000);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_bclk", 32'(bclk), 32'd0);
        chk("rst_bclk_x8", 32'(bclk_x8), 32'd0);
        idle(3);
        rx_data = 1'b1;
        idle(1);
        rst_n = 1'b1;
        mem_rd(32'd3, 8'h00);
        idle(BIT_CLKS * 2);
        send_frame(8'h5A, 1'b1, 10'h2B4);
        idle(BIT_CLKS);

        chk("rx_queue_drained", 32'(rx_q.size()), 32'd0);
        chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_mem_core.md
UART_RX_MEM_CORE -- requirements
Module: uart_rx_mem_core

Interface
REQ-001 Parameter CLK_HZ, default 768000, system clock frequency in Hz.
REQ-002 Parameter BAUD_SEL, default 0, baud select: 0=9600, 1=19200, 2=57600, 3=115200; other values SHALL select 9600.
REQ-003 Parameter ROW, default 2, matrix rows; COLUMN, default 2, matrix columns; memory depth = ROW*COLUMN bytes.
REQ-004 clk  input  1  sole clock; all state SHALL change only on its rising edge, except reset.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 rx_data  input  1  UART serial line, idle high.
REQ-007 mem_write  input  1  memory write enable.
REQ-008 write_address  input  32  memory write index.
REQ-009 write_value  input  8  memory write data.
REQ-010 mem_read  input  1  memory read enable.
REQ-011 read_address  input  32  memory read index.
REQ-012 data  output  8  registered memory read data.
REQ-013 bclk  output  1  one-cycle baud tick.
REQ-014 bclk_x8  output  1  one-cycle 8x-oversample tick.
REQ-015 rx_status  output  1  high while a frame is being received.
REQ-016 rx_output  output  10  last frame: [0]=start, [8:1]=data (LSB first), [9]=stop.
REQ-017 rx_valid  output  1  one-cycle pulse when rx_output updates.
REQ-018 frame_error  output  1  stop bit of last frame sampled low.

Function
REQ-019 Baud generator: DIV8 = CLK_HZ/(BAUD*8), integer truncation; bclk_x8 SHALL pulse 1 cycle every DIV8 clocks; bclk SHALL pulse on every 8th bclk_x8 pulse.
REQ-020 rx_data SHALL pass through a 2-flop synchronizer before use; all receiver timing is measured from the synchronized signal.
REQ-021 Receiver states: IDLE, START, DATA, STOP; all transitions occur only on bclk_x8 cycles.
REQ-022 IDLE: synchronized line sampled low on a bclk_x8 cycle -> START, tick counter cleared.
REQ-023 START: on 4th subsequent tick, line low -> DATA, rx_status=1; line high -> IDLE (glitch, no output change).
REQ-024 DATA: sample one bit every 8 ticks, LSB first, 8 bits total, then -> STOP.
REQ-025 STOP: sample 8 ticks after last data bit; in the same cycle load rx_output={stop,data,1'b0}, pulse rx_valid, set frame_error=~stop, clear rx_status, -> IDLE.
REQ-026 A new start bit SHALL be accepted on the first tick after return to IDLE; back-to-back frames SHALL be received without loss.
REQ-027 rx_output and frame_error SHALL hold between frames.
REQ-028 Memory: ROW*COLUMN x 8-bit array; mem_write=1 at a clock edge with write_address < depth writes write_value; out-of-range writes are ignored.
REQ-029 mem_read=1 at a clock edge: data <= mem[read_address] (1-cycle latency); out-of-range address -> data <= 0; mem_read=0 -> data holds.
REQ-030 Simultaneous read and write to the same address SHALL return the old contents (read-before-write).

Reset
REQ-031 rst_n low SHALL immediately clear: divider counters, bclk, bclk_x8, receiver to IDLE, rx_status, rx_valid, frame_error, rx_output=10'h000, data=0, all memory entries=0.
REQ-032 Reset mid-frame SHALL abort the frame with no rx_valid; reception resumes at the next start bit after rst_n rises.

Verification
REQ-033 Defaults (DIV8=10): bclk_x8 pulses every 10 clocks, bclk every 80 clocks after reset release.
REQ-034 Send 8'hA5 with valid stop -> rx_valid pulse, rx_output=10'h34A, frame_error=0, rx_status high during frame.
REQ-035 Send 8'h3C with stop bit low -> rx_output[8:1]=8'h3C, frame_error=1.
REQ-036 Low glitch of 20 clocks on idle line -> no rx_status, no rx_valid.
REQ-037 Write 8'h11,8'h22,8'h33,8'h44 to addresses 0-3, write 8'hFF to address 4; read 0-4 -> 11,22,33,44,00 each one cycle after mem_read.
REQ-038 Assert rst_n low mid-frame -> all outputs zero immediately; next full frame 8'h5A received correctly.
